// File: rtl/pipeline_pkg.sv
// Shared pipeline types: decoded control bundle and ALU opcodes.
// Used by decode, the ID/EX stage register and EX.
package pipeline_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_LUI  = 5'd9
    } aluOp_t;

    typedef struct packed {
        aluOp_t aluOp;
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   memToReg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: a load held in ID/EX whose destination a decoding instruction reads.
// Combinational, zero latency; no flow control of its own.
// Register 0 never hazards because it is never written.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic       exValid,
    input  logic       exMemRead,
    input  logic [4:0] exDestRegister,
    input  logic       idValid,
    input  logic [4:0] idRegisterRs,
    input  logic [4:0] idRegisterRt,
    input  logic       idUsesRt,
    output logic       loadUse
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (exDestRegister == idRegisterRs);
    assign rtMatch = idUsesRt && (exDestRegister == idRegisterRt);

    assign loadUse = exValid && exMemRead && (exDestRegister != REG_ZERO) &&
                     idValid && (rsMatch || rtMatch);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB bypass and stall counting.
// Latency: one cycle from accepting edge to outputs.
// Backpressure: !inExReady holds every output and stalls ID; flush overrides hold.
module idex_stage
    import pipeline_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [4:0]                inRegisterRs,
    input  logic [4:0]                inRegisterRt,
    input  logic [4:0]                inRegisterRd,
    input  logic                      inUsesRt,
    input  logic [BUS_DATA_WIDTH-1:0] inRsData,
    input  logic [BUS_DATA_WIDTH-1:0] inRtData,
    input  logic [BUS_DATA_WIDTH-1:0] inImm,
    input  ctrl_t                     inCtrl,
    input  logic                      inRegWriteWb,
    input  logic [4:0]                inDestRegisterWb,
    input  logic [BUS_DATA_WIDTH-1:0] inWbData,
    input  logic                      inExReady,
    input  logic                      inFlush,
    output logic                      outValid,
    output logic [4:0]                outRegisterRs,
    output logic [4:0]                outRegisterRt,
    output logic [4:0]                outDestRegisterEx,
    output logic [BUS_DATA_WIDTH-1:0] outRsData,
    output logic [BUS_DATA_WIDTH-1:0] outRtData,
    output logic [BUS_DATA_WIDTH-1:0] outImm,
    output ctrl_t                     outCtrl,
    output logic                      outStallId,
    output logic [31:0]               outStallCount
);

    logic loadUse;
    logic rsBypass;
    logic rtBypass;
    logic insertBubble;

    hazard_detect uHazardDetect (
        .exValid        (outValid),
        .exMemRead      (outCtrl.memRead),
        .exDestRegister (outDestRegisterEx),
        .idValid        (inValid),
        .idRegisterRs   (inRegisterRs),
        .idRegisterRt   (inRegisterRt),
        .idUsesRt       (inUsesRt),
        .loadUse        (loadUse)
    );

    assign outStallId = !inFlush && (!inExReady || loadUse);

    // The register file is written this same edge, so its read data is stale.
    assign rsBypass = inRegWriteWb && (inDestRegisterWb != REG_ZERO) &&
                      (inDestRegisterWb == inRegisterRs);
    assign rtBypass = inRegWriteWb && (inDestRegisterWb != REG_ZERO) &&
                      (inDestRegisterWb == inRegisterRt);

    // Flush wins over hold; an empty decode slot captures as a bubble.
    assign insertBubble = inFlush || (inExReady && (loadUse || !inValid));

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid          <= 1'b0;
            outRegisterRs     <= REG_ZERO;
            outRegisterRt     <= REG_ZERO;
            outDestRegisterEx <= REG_ZERO;
            outRsData         <= '0;
            outRtData         <= '0;
            outImm            <= '0;
            outCtrl           <= CTRL_NOP;
            outStallCount     <= '0;
        end else begin
            if (outStallId && (outStallCount != 32'hFFFF_FFFF)) begin
                outStallCount <= outStallCount + 32'd1;
            end
            if (insertBubble) begin
                outValid          <= 1'b0;
                outRegisterRs     <= REG_ZERO;
                outRegisterRt     <= REG_ZERO;
                outDestRegisterEx <= REG_ZERO;
                outRsData         <= '0;
                outRtData         <= '0;
                outImm            <= '0;
                outCtrl           <= CTRL_NOP;
            end else if (inExReady) begin
                outValid          <= 1'b1;
                outRegisterRs     <= inRegisterRs;
                outRegisterRt     <= inRegisterRt;
                outDestRegisterEx <= inRegisterRd;
                outRsData         <= rsBypass ? inWbData : inRsData;
                outRtData         <= rtBypass ? inWbData : inRtData;
                outImm            <= inImm;
                outCtrl           <= inCtrl;
            end
        end
    end

endmodule

// File: tb/tb_idex_stage.sv
// Directed test of idex_stage: reset, load-use bubble, hold, flush, WB bypass, r0, reset-in-hold.
module tb_idex_stage;
    import pipeline_pkg::*;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic [4:0]    inRegisterRs, inRegisterRt, inRegisterRd;
    logic          inUsesRt;
    logic [W-1:0]  inRsData, inRtData, inImm;
    ctrl_t         inCtrl;
    logic          inRegWriteWb;
    logic [4:0]    inDestRegisterWb;
    logic [W-1:0]  inWbData;
    logic          inExReady;
    logic          inFlush;
    logic          outValid;
    logic [4:0]    outRegisterRs, outRegisterRt, outDestRegisterEx;
    logic [W-1:0]  outRsData, outRtData, outImm;
    ctrl_t         outCtrl;
    logic          outStallId;
    logic [31:0]   outStallCount;

    int errCnt = 0;
    int chkCnt = 0;

    ctrl_t ldCtrl;
    ctrl_t addCtrl;

    idex_stage #(.BUS_DATA_WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .inValid           (inValid),
        .inRegisterRs      (inRegisterRs),
        .inRegisterRt      (inRegisterRt),
        .inRegisterRd      (inRegisterRd),
        .inUsesRt          (inUsesRt),
        .inRsData          (inRsData),
        .inRtData          (inRtData),
        .inImm             (inImm),
        .inCtrl            (inCtrl),
        .inRegWriteWb      (inRegWriteWb),
        .inDestRegisterWb  (inDestRegisterWb),
        .inWbData          (inWbData),
        .inExReady         (inExReady),
        .inFlush           (inFlush),
        .outValid          (outValid),
        .outRegisterRs     (outRegisterRs),
        .outRegisterRt     (outRegisterRt),
        .outDestRegisterEx (outDestRegisterEx),
        .outRsData         (outRsData),
        .outRtData         (outRtData),
        .outImm            (outImm),
        .outCtrl           (outCtrl),
        .outStallId        (outStallId),
        .outStallCount     (outStallCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic usesRt,
                            input logic [W-1:0] rsD, input logic [W-1:0] rtD,
                            input logic [W-1:0] imm, input ctrl_t c);
        inValid      = v;
        inRegisterRs = rs;
        inRegisterRt = rt;
        inRegisterRd = rd;
        inUsesRt     = usesRt;
        inRsData     = rsD;
        inRtData     = rtD;
        inImm        = imm;
        inCtrl       = c;
    endtask

    // Registered outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ldCtrl  = '{aluOp: ALU_ADD, regWrite: 1'b1, memRead: 1'b1, memWrite: 1'b0, memToReg: 1'b1};
        addCtrl = '{aluOp: ALU_ADD, regWrite: 1'b1, memRead: 1'b0, memWrite: 1'b0, memToReg: 1'b0};

        reset = 1'b1;
        setInstr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, '0, '0, CTRL_NOP);
        inRegWriteWb = 1'b0; inDestRegisterWb = 5'd0; inWbData = '0;
        inExReady = 1'b1; inFlush = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(outValid), 64'd0);
        check("rst_rd", 64'(outDestRegisterEx), 64'd0);
        check("rst_rsdata", outRsData, 64'd0);
        check("rst_ctrl", 64'(outCtrl), 64'd0);
        check("rst_count", 64'(outStallCount), 64'd0);
        check("rst_stall", 64'(outStallId), 64'd0);
        reset = 1'b0;

        // Load x5 then dependent add: one bubble, one stall cycle.
        setInstr(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, 64'h100, 64'h0, 64'h8, ldCtrl);
        #1 check("ld_nostall", 64'(outStallId), 64'd0);
        tick();
        check("ld_valid", 64'(outValid), 64'd1);
        check("ld_rd", 64'(outDestRegisterEx), 64'd5);
        check("ld_memread", 64'(outCtrl.memRead), 64'd1);
        setInstr(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 64'h11, 64'h22, 64'h0, addCtrl);
        #1 check("lu_stall", 64'(outStallId), 64'd1);
        tick();
        check("bub_valid", 64'(outValid), 64'd0);
        check("bub_rd", 64'(outDestRegisterEx), 64'd0);
        check("bub_ctrl", 64'(outCtrl), 64'd0);
        check("bub_count", 64'(outStallCount), 64'd1);
        #1 check("bub_nostall", 64'(outStallId), 64'd0);
        tick();
        check("add_valid", 64'(outValid), 64'd1);
        check("add_rd", 64'(outDestRegisterEx), 64'd8);
        check("add_rsdata", outRsData, 64'h11);
        check("add_count", 64'(outStallCount), 64'd1);

        // Hold for three cycles while a load rd=9 waits in decode.
        inExReady = 1'b0;
        setInstr(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 64'h33, 64'h44, 64'h4, ldCtrl);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", 64'(outStallId), 64'd1);
            tick();
            check("hold_rd", 64'(outDestRegisterEx), 64'd8);
            check("hold_rsdata", outRsData, 64'h11);
            check("hold_valid", 64'(outValid), 64'd1);
        end
        check("hold_count", 64'(outStallCount), 64'd4);
        inExReady = 1'b1;
        tick();
        check("ld9_rd", 64'(outDestRegisterEx), 64'd9);
        check("ld9_rtdata", outRtData, 64'h44);

        // Flush with a pending load-use and EX not ready.
        inExReady = 1'b0; inFlush = 1'b1;
        setInstr(1'b1, 5'd9, 5'd1, 5'd10, 1'b0, 64'h1, 64'h2, 64'h3, addCtrl);
        #1 check("fl_stall", 64'(outStallId), 64'd0);
        tick();
        check("fl_valid", 64'(outValid), 64'd0);
        check("fl_ctrl", 64'(outCtrl), 64'd0);
        check("fl_rd", 64'(outDestRegisterEx), 64'd0);
        check("fl_count", 64'(outStallCount), 64'd4);
        inExReady = 1'b1; inFlush = 1'b0;

        // WB bypass of r7 to both operands.
        inRegWriteWb = 1'b1; inDestRegisterWb = 5'd7; inWbData = 64'hDEAD;
        setInstr(1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 64'h1, 64'h2, 64'h0, addCtrl);
        tick();
        check("byp_rs", outRsData, 64'hDEAD);
        check("byp_rt", outRtData, 64'hDEAD);
        setInstr(1'b1, 5'd4, 5'd7, 5'd3, 1'b1, 64'h77, 64'h88, 64'h0, addCtrl);
        tick();
        check("byp_rs_only_rt", outRsData, 64'h77);
        check("byp_rt_only_rt", outRtData, 64'hDEAD);
        // WB to r0 must not be bypassed.
        inDestRegisterWb = 5'd0; inWbData = 64'hBEEF;
        setInstr(1'b1, 5'd0, 5'd7, 5'd3, 1'b1, 64'h55, 64'h66, 64'h0, addCtrl);
        tick();
        check("r0_rs", outRsData, 64'h55);
        check("r0_rt", outRtData, 64'h66);
        inRegWriteWb = 1'b0;

        // Load to r0 followed by an r0 reader: no hazard.
        setInstr(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 64'h0, 64'h0, 64'h0, ldCtrl);
        tick();
        setInstr(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 64'h9, 64'h0, 64'h0, addCtrl);
        #1 check("ldr0_stall", 64'(outStallId), 64'd0);
        tick();
        check("ldr0_valid", 64'(outValid), 64'd1);
        check("ldr0_rd", 64'(outDestRegisterEx), 64'd2);
        check("ldr0_count", 64'(outStallCount), 64'd4);

        // Empty decode slot captures as a bubble.
        setInstr(1'b0, 5'd3, 5'd4, 5'd6, 1'b1, 64'hAA, 64'hBB, 64'hCC, addCtrl);
        tick();
        check("inv_valid", 64'(outValid), 64'd0);
        check("inv_rsdata", outRsData, 64'd0);
        check("inv_imm", outImm, 64'd0);

        // Reset while holding a valid entry.
        setInstr(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 64'hAA, 64'hBB, 64'hCC, addCtrl);
        tick();
        check("pre_valid", 64'(outValid), 64'd1);
        inExReady = 1'b0;
        tick();
        check("pre_count", 64'(outStallCount), 64'd5);
        reset = 1'b1;
        #1 check("rst_hold_stall", 64'(outStallId), 64'd1);
        tick();
        check("rh_valid", 64'(outValid), 64'd0);
        check("rh_rd", 64'(outDestRegisterEx), 64'd0);
        check("rh_rt", 64'(outRegisterRt), 64'd0);
        check("rh_imm", outImm, 64'd0);
        check("rh_count", 64'(outStallCount), 64'd0);
        reset = 1'b0; inExReady = 1'b1;
        #1 check("post_rst_stall", 64'(outStallId), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 Parameter: BUS_DATA_WIDTH, default 64, width of register operands and immediate.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 inValid  input  1  decode presents a valid instruction this cycle.
REQ-005 inRegisterRs, inRegisterRt, inRegisterRd  input  5 each  decoded source/dest register numbers.
REQ-006 inUsesRt  input  1  instruction reads Rt as a source operand.
REQ-007 inRsData, inRtData, inImm  input  BUS_DATA_WIDTH each  register-file read data and sign-extended immediate.
REQ-008 inCtrl  input  ctrl_t  decoded control: aluOp[4:0], regWrite, memRead, memWrite, memToReg.
REQ-009 inRegWriteWb, inDestRegisterWb, inWbData  input  1/5/BUS_DATA_WIDTH  writeback port, same cycle as register-file write.
REQ-010 inExReady  input  1  EX can accept the held instruction this cycle.
REQ-011 inFlush  input  1  branch/jump redirect; discard decode input and held entry.
REQ-012 outValid, outRegisterRs, outRegisterRt, outDestRegisterEx, outRsData, outRtData, outImm, outCtrl  output  as inputs  registered ID/EX contents to EX and forwarding unit.
REQ-013 outStallId  output  1  combinational; holds PC and IF/ID register this cycle.
REQ-014 outStallCount  output  32  saturating count of stall cycles.

Function
REQ-015 Per-edge priority SHALL be: reset > inFlush > hold (!inExReady) > load-use bubble > capture.
REQ-016 loadUse SHALL be outValid & outCtrl.memRead & outDestRegisterEx!=0 & inValid & (outDestRegisterEx==inRegisterRs | (inUsesRt & outDestRegisterEx==inRegisterRt)).
REQ-017 outStallId SHALL equal !inFlush & (!inExReady | loadUse).
REQ-018 Hold: when !inExReady and !inFlush, every registered output SHALL keep its value.
REQ-019 Bubble: on loadUse with inExReady, register SHALL load outValid=0, all register numbers 0, outCtrl all zero, data fields 0.
REQ-020 Capture: otherwise register SHALL load all inputs, outValid=inValid; inValid=0 SHALL load bubble contents per REQ-019.
REQ-021 WB bypass: on capture, if inRegWriteWb & inDestRegisterWb!=0 & inDestRegisterWb==inRegisterRs, outRsData SHALL load inWbData; same rule independently for Rt.
REQ-022 Register 0 SHALL never be bypassed; its captured data SHALL be inRsData/inRtData unmodified.
REQ-023 Flush: outValid and outCtrl SHALL clear next edge, register numbers clear to 0, regardless of inExReady or loadUse.
REQ-024 Latency: captured instruction SHALL appear on outputs exactly 1 cycle after the accepting edge.
REQ-025 A load followed by a dependent instruction SHALL cost exactly one bubble; the hazard SHALL self-clear because the load leaves the stage.
REQ-026 outStallCount SHALL increment on each edge where outStallId=1 and SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-027 On reset: outValid=0, all register numbers 0, data fields 0, outCtrl zero, outStallCount=0.
REQ-028 Reset mid-stall SHALL drop the held instruction; outStallId follows inputs combinationally after reset.

Structure
REQ-029 ctrl_t packed struct and ALU opcode enum SHALL live in shared package pipeline_pkg, also used by decode and EX.
REQ-030 Load-use comparator SHALL be sub-module hazard_detect (combinational, outputs loadUse).
REQ-031 Single always_ff for the stage register and counter; no other state.

Verification
REQ-032 Load x5 (memRead, rd=5) then add rs=5 -> outStallId=1 one cycle, one bubble (outValid=0, rd=0), add issues next cycle; outStallCount=1.
REQ-033 inExReady=0 for 3 cycles with valid held entry -> outputs unchanged, outStallId=1 each cycle, outStallCount=3.
REQ-034 inFlush=1 concurrent with loadUse and inExReady=0 -> next edge outValid=0, outStallId=0 that cycle.
REQ-035 WB writes r7=0xDEAD while decode reads rs=7, rt=7 -> outRsData=outRtData=0xDEAD; WB to r0 with rs=0 -> outRsData=inRsData.
REQ-036 Load rd=0 followed by rs=0 consumer -> no stall, no bubble.
REQ-037 Assert reset during hold with outValid=1 -> next edge all outputs zero, outStallCount=0.
